mpeg_out_drain: RTL and testbench

//  Reader for the descrambler output FIFO (mpeg_out/mpeg_rd/mpeg_empty, 1-cycle read latency).

---
 rtl/mpeg_out_drain_if.sv | 20 ++
 rtl/mpeg_out_drain.sv | 113 +++++++++++
 tb/tb_mpeg_out_drain.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mpeg_out_drain_if.sv
// FIFO-read and downstream valid/ready signals of the MPEG output drain.
// master = drain side, slave = FIFO/sink side.
interface mpeg_out_drain_if;
  logic [7:0] mpeg_out;
  logic       mpeg_empty;
  logic       mpeg_rd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    input  mpeg_out, mpeg_empty, out_ready,
    output mpeg_rd, out_data, out_valid
  );

  modport slave (
    output mpeg_out, mpeg_empty, out_ready,
    input  mpeg_rd, out_data, out_valid
  );
endinterface

// File: rtl/mpeg_out_drain.sv
// Drains a 1-cycle-latency FIFO into a BUF_DEPTH buffer (first out_valid 2 cycles after first read),
// reads are credit-limited so out_ready=0 stalls reads once the buffer is full; counts bytes and 00 00 01.
module mpeg_out_drain #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             stream_end,
  input  logic [CNT_W-1:0] expected_cnt,
  mpeg_out_drain_if.master bus,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] sc_cnt,
  output logic             done,
  output logic             cnt_err
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [7:0]       mem_q [BUF_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q, occ_d, occ_sum;
  logic             inflight_q;
  logic             end_q;
  logic [7:0]       h1_q, h0_q;
  logic [CNT_W-1:0] byte_cnt_q, sc_cnt_q;
  logic             done_q, cnt_err_q;

  logic rd, push, pop, is_sc, end_seen;

  // Credit check counts the byte already in flight so the buffer can never overflow.
  assign occ_sum  = occ_q + {{AW{1'b0}}, inflight_q};
  assign rd       = ~rst & clk_en & ~bus.mpeg_empty & (occ_sum < OW'(BUF_DEPTH)) & (state_q != DONE);
  assign push     = clk_en & inflight_q;
  assign pop      = clk_en & bus.out_valid & bus.out_ready;
  assign is_sc    = (bus.out_data == 8'h01) && (h1_q == 8'h00) && (h0_q == 8'h00);
  assign end_seen = end_q | stream_end;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  assign bus.mpeg_rd   = rd;
  assign bus.out_valid = (occ_q != '0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign byte_cnt      = byte_cnt_q;
  assign sc_cnt        = sc_cnt_q;
  assign done          = done_q;
  assign cnt_err       = cnt_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      end_q      <= 1'b0;
      h1_q       <= 8'hFF;
      h0_q       <= 8'hFF;
      byte_cnt_q <= '0;
      sc_cnt_q   <= '0;
      done_q     <= 1'b0;
      cnt_err_q  <= 1'b0;
    end else if (clk_en) begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.mpeg_out;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        h1_q       <= h0_q;
        h0_q       <= bus.out_data;
        byte_cnt_q <= byte_cnt_q + 1'b1;
        if (is_sc) sc_cnt_q <= sc_cnt_q + 1'b1;
      end
      occ_q      <= occ_d;
      inflight_q <= rd;
      if (stream_end) end_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (end_seen)  state_q <= DRAIN;
          else if (rd)   state_q <= RUN;
        end
        RUN: begin
          if (end_seen)  state_q <= DRAIN;
        end
        DRAIN: begin
          // occ=0 guarantees no transfer this cycle, so byte_cnt_q is final here.
          if (bus.mpeg_empty && !inflight_q && (occ_q == '0) && !rd) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            cnt_err_q <= (byte_cnt_q != expected_cnt);
          end
        end
        default: state_q <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpeg_out_drain.sv
// Scoreboarded bench: a queue-backed FIFO model feeds the drain, expected bytes are
// queued at push time and popped when a downstream transfer is observed.
module tb_mpeg_out_drain;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clk_en = 1'b1;
  logic             stream_end = 1'b0;
  logic [CNT_W-1:0] expected_cnt = '0;
  logic [CNT_W-1:0] byte_cnt, sc_cnt;
  logic             done, cnt_err;

  mpeg_out_drain_if ifc ();

  mpeg_out_drain #(.BUF_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .stream_end   (stream_end),
    .expected_cnt (expected_cnt),
    .bus          (ifc),
    .byte_cnt     (byte_cnt),
    .sc_cnt       (sc_cnt),
    .done         (done),
    .cnt_err      (cnt_err)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  int         rd_pulses = 0;
  int         total = 0;
  int         bad = 0;
  logic       rand_mode = 1'b0;

  // FIFO model: data appears the cycle after mpeg_rd and is held otherwise.
  initial ifc.mpeg_empty = 1'b1;
  initial ifc.mpeg_out   = 8'h00;
  always @(posedge clk) begin
    if (ifc.mpeg_rd) begin
      rd_pulses <= rd_pulses + 1;
      if (fifo_q.size() != 0) ifc.mpeg_out <= fifo_q.pop_front();
    end
    ifc.mpeg_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stream_end = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    #1;
    chk("rst_mpeg_rd",   {31'd0, ifc.mpeg_rd},   32'd0);
    chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, ifc.out_data},  32'd0);
    chk("rst_byte_cnt",  byte_cnt, 32'd0);
    chk("rst_sc_cnt",    sc_cnt,   32'd0);
    chk("rst_done",      {31'd0, done},    32'd0);
    chk("rst_cnt_err",   {31'd0, cnt_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic end_and_wait_done(input string tag, input int max_cyc);
    int n = 0;
    stream_end = 1'b1;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] sc_bytes [11];
    int base;
    sc_bytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hB3, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
    ifc.out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        #4;
        if (!rst && ifc.out_valid && ifc.out_ready && clk_en) begin
          if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, ifc.out_data}, 32'hFFFF_FFFF);
          else                   chk("out_data", {24'd0, ifc.out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      forever begin
        @(negedge clk);
        if (rand_mode) begin
          ifc.out_ready = 1'($urandom_range(0, 1));
          clk_en        = ($urandom_range(0, 7) != 0);
        end
      end
    join_none

    // 10 sequential bytes, always ready
    do_reset();
    expected_cnt = 10;
    for (int i = 0; i < 10; i++) push_byte(8'(i));
    wait_drain("t1_drain_timeout", 200);
    end_and_wait_done("t1_done", 20);
    chk("t1_byte_cnt", byte_cnt, 32'd10);
    chk("t1_cnt_err",  {31'd0, cnt_err}, 32'd0);

    // backpressure: exactly BUF_DEPTH reads, stable head
    do_reset();
    ifc.out_ready = 1'b0;
    base = rd_pulses;
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    repeat (12) @(negedge clk);
    chk("t2_rd_pulses", 32'(rd_pulses - base), 32'd4);
    chk("t2_out_valid", {31'd0, ifc.out_valid}, 32'd1);
    chk("t2_head",      {24'd0, ifc.out_data},  32'h20);
    repeat (3) @(negedge clk);
    chk("t2_head_stable", {24'd0, ifc.out_data}, 32'h20);
    chk("t2_rd_pulses_hold", 32'(rd_pulses - base), 32'd4);
    ifc.out_ready = 1'b1;
    wait_drain("t2_drain_timeout", 200);
    chk("t2_byte_cnt", byte_cnt, 32'd8);

    // start-code prefixes
    do_reset();
    expected_cnt = 11;
    for (int i = 0; i < 11; i++) push_byte(sc_bytes[i]);
    wait_drain("t3_drain_timeout", 200);
    end_and_wait_done("t3_done", 20);
    chk("t3_sc_cnt",   sc_cnt,   32'd3);
    chk("t3_byte_cnt", byte_cnt, 32'd11);
    chk("t3_cnt_err",  {31'd0, cnt_err}, 32'd0);

    // empty stream: done within 2 cycles
    do_reset();
    expected_cnt = 0;
    stream_end = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t4_done_2cyc", {31'd0, done},    32'd1);
    chk("t4_byte_cnt",  byte_cnt,         32'd0);
    chk("t4_cnt_err",   {31'd0, cnt_err}, 32'd0);

    // count mismatch, then nothing read after done
    do_reset();
    expected_cnt = 6;
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    wait_drain("t5_drain_timeout", 200);
    end_and_wait_done("t5_done", 20);
    chk("t5_byte_cnt", byte_cnt, 32'd5);
    chk("t5_cnt_err",  {31'd0, cnt_err}, 32'd1);
    base = rd_pulses;
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h66);
    repeat (6) @(negedge clk);
    chk("t5_no_rd_after_done", 32'(rd_pulses - base), 32'd0);
    chk("t5_no_valid_after_done", {31'd0, ifc.out_valid}, 32'd0);
    chk("t5_done_sticky", {31'd0, done}, 32'd1);

    // reset in the middle of a stream
    do_reset();
    for (int i = 0; i < 10; i++) push_byte(8'h70 + 8'(i));
    repeat (5) @(negedge clk);
    do_reset();

    // long random backpressure and clock-enable run
    expected_cnt = 5000;
    for (int i = 0; i < 5000; i++) push_byte(8'($urandom_range(0, 255)));
    rand_mode = 1'b1;
    wait_drain("t6_drain_timeout", 60000);
    rand_mode = 1'b0;
    @(negedge clk);
    clk_en = 1'b1;
    ifc.out_ready = 1'b1;
    end_and_wait_done("t6_done", 20);
    chk("t6_byte_cnt", byte_cnt, 32'd5000);
    chk("t6_cnt_err",  {31'd0, cnt_err}, 32'd0);
    chk("t6_leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
